// File: rtl/uart_cipher_sequencer.sv
// Automatic Rx-FIFO -> SIMON cipher -> Tx-FIFO block sequencer for the UART core.
// Optional cipher watchdog enabled by defining SEQ_TIMEOUT_EN.
module uart_cipher_sequencer #(
    parameter int BLOCK_W     = 64,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int TO_W        = 20
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               rx_full,
    input  logic               rx_empty,
    input  logic [BLOCK_W-1:0] block_in,
    output logic               rx_fifo_rd,
    input  logic               mode,
    output logic               cipher_start,
    output logic               cipher_mode,
    output logic [BLOCK_W-1:0] cipher_pt,
    input  logic               cipher_done,
    input  logic [BLOCK_W-1:0] cipher_out,
    input  logic               tx_empty,
    output logic               tx_fifo_wr,
    output logic [BLOCK_W-1:0] block_out,
    output logic               busy,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   blocks_done,
    output logic               err
);

    // state   | meaning
    // IDLE    | waiting for a full 8-byte block in the Rx FIFO
    // READ    | pop pulse to Rx FIFO, capture block and mode
    // START   | start pulse to cipher core
    // WAIT    | waiting for cipher done
    // LOAD    | waiting for an empty Tx FIFO, then one push pulse
    // DRAIN   | waiting for the Tx FIFO to empty again
    // ERROR   | cipher watchdog expired; left only by reset
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_LOAD  = 3'd4,
        S_DRAIN = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t st, st_next;
    logic   drain_seen;
    logic   drain_tmr;
    logic   wd_expired;
    logic   unused_rx_empty;

    assign unused_rx_empty = rx_empty;
    assign busy            = (st != S_IDLE);
    assign state           = st;

    always_comb begin
        st_next = st;
        case (st)
            S_IDLE:  if (rx_full) st_next = S_READ;
            S_READ:  st_next = S_START;
            S_START: st_next = S_WAIT;
            S_WAIT: begin
                if (cipher_done)     st_next = S_LOAD;
                else if (wd_expired) st_next = S_ERROR;
            end
            // the push pulse is already on the port when LOAD moves on
            S_LOAD:  if (tx_fifo_wr) st_next = S_DRAIN;
            // Tx empty flag can lag the push by a cycle, so only trust it once
            // it has been seen low or the settle timer has run out
            S_DRAIN: if (tx_empty && (drain_seen || (drain_tmr == 1'b0))) st_next = S_IDLE;
            S_ERROR: st_next = S_ERROR;
            default: st_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            st           <= S_IDLE;
            rx_fifo_rd   <= 1'b0;
            cipher_start <= 1'b0;
            tx_fifo_wr   <= 1'b0;
            cipher_pt    <= '0;
            cipher_mode  <= 1'b0;
            block_out    <= '0;
            blocks_done  <= '0;
            drain_seen   <= 1'b0;
            drain_tmr    <= 1'b0;
        end else begin
            st           <= st_next;
            rx_fifo_rd   <= (st == S_IDLE) && rx_full;
            cipher_start <= (st == S_READ);
            tx_fifo_wr   <= ((st == S_WAIT) && cipher_done && tx_empty) ||
                            ((st == S_LOAD) && !tx_fifo_wr && tx_empty);
            if (st == S_READ) begin
                cipher_pt   <= block_in;
                cipher_mode <= mode;
            end
            if ((st == S_WAIT) && cipher_done) block_out <= cipher_out;
            if (st != S_DRAIN) begin
                drain_seen <= 1'b0;
                drain_tmr  <= 1'b1;
            end else begin
                drain_seen <= drain_seen | ~tx_empty;
                drain_tmr  <= 1'b0;
            end
            if ((st == S_DRAIN) && (st_next == S_IDLE)) blocks_done <= blocks_done + 1'b1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [TO_W-1:0] wd_cnt;
    logic            err_q;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (st != S_WAIT)        wd_cnt <= TO_W'(TIMEOUT_CYC - 1);
            else if (wd_cnt != '0)   wd_cnt <= wd_cnt - 1'b1;
            if (st_next == S_ERROR)  err_q  <= 1'b1;
        end
    end

    assign wd_expired = (wd_cnt == '0);
    assign err        = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYC[0], TO_W[0]};
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cipher_sequencer.sv
// Directed bench for uart_cipher_sequencer; watchdog case runs when SEQ_TIMEOUT_EN is defined.
module tb_uart_cipher_sequencer;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        rx_full, rx_empty, mode, cipher_done, tx_empty;
    logic [63:0] block_in, cipher_out;
    logic        rx_fifo_rd, cipher_start, cipher_mode, tx_fifo_wr, busy, err;
    logic [63:0] cipher_pt, block_out;
    logic [2:0]  state;
    logic [15:0] blocks_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_rd = 0, cnt_start = 0, cnt_wr = 0, n_overlap = 0;
    int base_rd, base_start, base_wr;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_cipher_sequencer #(
        .BLOCK_W(64), .CNT_W(16), .TIMEOUT_CYC(100), .TO_W(20)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .rx_full(rx_full), .rx_empty(rx_empty), .block_in(block_in),
        .rx_fifo_rd(rx_fifo_rd), .mode(mode),
        .cipher_start(cipher_start), .cipher_mode(cipher_mode), .cipher_pt(cipher_pt),
        .cipher_done(cipher_done), .cipher_out(cipher_out),
        .tx_empty(tx_empty), .tx_fifo_wr(tx_fifo_wr), .block_out(block_out),
        .busy(busy), .state(state), .blocks_done(blocks_done), .err(err)
    );

    always @(negedge clk_100MHz) begin
        if (rx_fifo_rd)   cnt_rd++;
        if (cipher_start) cnt_start++;
        if (tx_fifo_wr)   cnt_wr++;
        if ((int'(rx_fifo_rd) + int'(cipher_start) + int'(tx_fifo_wr)) > 1) n_overlap++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string tag);
        int n = 0;
        while (state !== s && n < max) begin
            step();
            n++;
        end
        check(tag, state, s);
    endtask

    task automatic mark();
        base_rd = cnt_rd;
        base_start = cnt_start;
        base_wr = cnt_wr;
    endtask

    // IDLE -> READ -> START -> WAIT, dropping rx_full after the pop
    task automatic start_block(input logic [63:0] pt, input logic md);
        rx_full = 1'b1; block_in = pt; mode = md;
        step();
        check("sb_read", state, 3'd1);
        rx_full = 1'b0;
        step();
        check("sb_pt", cipher_pt, pt);
        step();
        check("sb_wait", state, 3'd3);
    endtask

    // WAIT -> LOAD (push) -> DRAIN -> IDLE with a well-behaved Tx FIFO
    task automatic finish_block(input logic [63:0] ct);
        cipher_done = 1'b1; cipher_out = ct; tx_empty = 1'b1;
        step();
        check("fb_wr", tx_fifo_wr, 1'b1);
        check("fb_out", block_out, ct);
        cipher_done = 1'b0; tx_empty = 1'b0;
        step();
        step();
        tx_empty = 1'b1;
        step();
        check("fb_idle", state, 3'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [63:0] t5_pt [3];
        t5_pt[0] = 64'h1111_2222_3333_4444;
        t5_pt[1] = 64'h5555_6666_7777_8888;
        t5_pt[2] = 64'h9999_AAAA_BBBB_CCCC;

        reset = 1'b1; rx_full = 1'b0; rx_empty = 1'b1; mode = 1'b0;
        cipher_done = 1'b0; tx_empty = 1'b1; block_in = '0; cipher_out = '0;
        step(); step();
        reset = 1'b0;
        check("rst_state", state, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {rx_fifo_rd, cipher_start, tx_fifo_wr}, 3'b000);
        check("rst_cnt", blocks_done, 16'd0);
        check("rst_err", err, 1'b0);
        check("rst_pt", cipher_pt, 64'd0);
        check("rst_bout", block_out, 64'd0);

        // T1 nominal
        step();
        check("t1_idle", state, 3'd0);
        rx_full = 1'b1; block_in = 64'h0123456789ABCDEF; mode = 1'b0; rx_empty = 1'b0;
        step();
        check("t1_rd", rx_fifo_rd, 1'b1);
        check("t1_st_read", state, 3'd1);
        check("t1_busy", busy, 1'b1);
        rx_full = 1'b0; rx_empty = 1'b1;
        step();
        check("t1_start", cipher_start, 1'b1);
        check("t1_rd_off", rx_fifo_rd, 1'b0);
        check("t1_pt", cipher_pt, 64'h0123456789ABCDEF);
        check("t1_mode", cipher_mode, 1'b0);
        step();
        check("t1_wait", state, 3'd3);
        check("t1_start_off", cipher_start, 1'b0);
        step();
        cipher_done = 1'b1; cipher_out = 64'hDEADBEEFCAFEF00D; tx_empty = 1'b1;
        step();
        cipher_done = 1'b0;
        check("t1_wr", tx_fifo_wr, 1'b1);
        check("t1_bout", block_out, 64'hDEADBEEFCAFEF00D);
        check("t1_load", state, 3'd4);
        tx_empty = 1'b0;
        step();
        check("t1_drain", state, 3'd5);
        check("t1_wr_off", tx_fifo_wr, 1'b0);
        step();
        check("t1_drain_hold", state, 3'd5);
        tx_empty = 1'b1;
        step();
        check("t1_done_idle", state, 3'd0);
        check("t1_cnt", blocks_done, 16'd1);

        // T2 backpressure, and tx_empty stuck high through DRAIN entry
        mark();
        start_block(64'hFEDCBA9876543210, 1'b1);
        check("t2_mode", cipher_mode, 1'b1);
        tx_empty = 1'b0; cipher_done = 1'b1; cipher_out = 64'h0F0F0F0F0F0F0F0F;
        step();
        cipher_done = 1'b0;
        check("t2_load", state, 3'd4);
        check("t2_no_wr", tx_fifo_wr, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("t2_hold", state, 3'd4);
        check("t2_hold_wr", cnt_wr - base_wr, 0);
        tx_empty = 1'b1;
        step();
        check("t2_wr", tx_fifo_wr, 1'b1);
        check("t2_bout", block_out, 64'h0F0F0F0F0F0F0F0F);
        step();
        check("t2_drain", state, 3'd5);
        step();
        check("t2_drain_settle", state, 3'd5);
        check("t2_cnt_hold", blocks_done, 16'd1);
        step();
        check("t2_idle", state, 3'd0);
        check("t2_cnt", blocks_done, 16'd2);
        check("t2_one_wr", cnt_wr - base_wr, 1);

        // T3 stray done in IDLE and in START
        mark();
        cipher_done = 1'b1;
        step();
        cipher_done = 1'b0;
        check("t3_idle_ign", state, 3'd0);
        rx_full = 1'b1; block_in = 64'hA5A5A5A5A5A5A5A5;
        step();
        rx_full = 1'b0;
        step();
        check("t3_in_start", state, 3'd2);
        cipher_done = 1'b1; cipher_out = 64'hBAD0BAD0BAD0BAD0;
        step();
        cipher_done = 1'b0;
        check("t3_start_ign", state, 3'd3);
        step();
        check("t3_still_wait", state, 3'd3);
        check("t3_no_wr", cnt_wr - base_wr, 0);
        finish_block(64'h1234123412341234);
        check("t3_cnt", blocks_done, 16'd3);

        // T4 reset mid-WAIT
        start_block(64'hCAFECAFECAFECAFE, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t4_state", state, 3'd0);
        check("t4_busy", busy, 1'b0);
        check("t4_cnt", blocks_done, 16'd0);
        check("t4_strobes", {rx_fifo_rd, cipher_start, tx_fifo_wr}, 3'b000);
        check("t4_pt", cipher_pt, 64'd0);
        start_block(64'h0BADF00D0BADF00D, 1'b1);
        finish_block(64'h5A5A5A5A5A5A5A5A);
        check("t4_restart_cnt", blocks_done, 16'd1);

        // T5 back-to-back with rx_full held high
        mark();
        rx_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            block_in = t5_pt[k];
            wait_state(3'd1, 4, "t5_read");
            if (k == 2) rx_full = 1'b0;
            step();
            check("t5_pt", cipher_pt, t5_pt[k]);
            step();
            finish_block(~t5_pt[k]);
        end
        step();
        check("t5_idle", state, 3'd0);
        check("t5_cnt", blocks_done, 16'd4);
        check("t5_rd", cnt_rd - base_rd, 3);
        check("t5_start", cnt_start - base_start, 3);
        check("t5_wr", cnt_wr - base_wr, 3);

`ifdef SEQ_TIMEOUT_EN
        // T6 watchdog: 100 WAIT cycles then sticky ERROR
        begin
            int n_wait = 0;
            start_block(64'h7777777777777777, 1'b0);
            while (state == 3'd3 && n_wait < 200) begin
                n_wait++;
                step();
            end
            check("t6_wait_cycles", n_wait, 100);
            check("t6_error", state, 3'd6);
            check("t6_err", err, 1'b1);
            mark();
            cipher_done = 1'b1; rx_full = 1'b1;
            step();
            cipher_done = 1'b0;
            for (int i = 0; i < 5; i++) step();
            rx_full = 1'b0;
            check("t6_sticky", state, 3'd6);
            check("t6_err_sticky", err, 1'b1);
            check("t6_no_strobes", (cnt_rd - base_rd) + (cnt_start - base_start) + (cnt_wr - base_wr), 0);
            reset = 1'b1;
            step();
            reset = 1'b0;
            check("t6_rst_err", err, 1'b0);
            check("t6_rst_state", state, 3'd0);
        end
`else
        // without the watchdog WAIT never gives up
        start_block(64'h7777777777777777, 1'b0);
        for (int i = 0; i < 150; i++) step();
        check("nowd_wait", state, 3'd3);
        check("nowd_err", err, 1'b0);
        finish_block(64'h8888888888888888);
        check("nowd_cnt", blocks_done, 16'd5);
`endif

        check("strobe_exclusive", n_overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
